// File: rtl/float_class_gen.sv
// float_class_gen
//    Stimulus source for FPU self-test. A request carries a one-hot class code
//    (the same encoding the classifier produces) and a beat count. The block
//    then emits a burst of half-precision values on a valid/ready stream. Each
//    value belongs to the requested class. Exponent and fraction bits come from
//    an internal 16-bit LFSR.
//
//    Ports
//       CLK        clock, rising edge
//       RST        synchronous active-high reset
//       req_valid  request present
//       req_ready  generator idle and able to accept a request
//       req_class  one-hot class code: 0 -inf, 1 -normal, 2 -subnormal, 3 -0,
//                  4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN
//       req_count  number of beats in the burst (0 is rejected)
//       out_valid  out_float holds a beat
//       out_ready  downstream accepts the beat
//       out_float  generated value
//       out_last   final beat of the burst
//       err        one-cycle pulse for a rejected request
//       busy       burst in progress
module float_class_gen #(
   parameter int          FLOAT_WIDTH    = 16,
   parameter int          EXPONENT_WIDTH = 5,
   parameter int          FRACTION_WIDTH = 10,
   parameter int          COUNT_W        = 8,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [9:0]             req_class,
   input  logic [COUNT_W-1:0]     req_count,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FLOAT_WIDTH-1:0] out_float,
   output logic                   out_last,
   output logic                   err,
   output logic                   busy
);

   // A seed of zero would lock the LFSR at zero, so it falls back to ACE1.
   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

   localparam logic [FLOAT_WIDTH-1:0] HALF_INF   = {1'b0, {EXPONENT_WIDTH{1'b1}}, {FRACTION_WIDTH{1'b0}}};
   localparam logic [FLOAT_WIDTH-1:0] HALF_INFN  = {1'b1, {EXPONENT_WIDTH{1'b1}}, {FRACTION_WIDTH{1'b0}}};
   localparam logic [FLOAT_WIDTH-1:0] HALF_ZERO  = {FLOAT_WIDTH{1'b0}};
   localparam logic [FLOAT_WIDTH-1:0] HALF_ZERON = {1'b1, {(FLOAT_WIDTH-1){1'b0}}};
   localparam logic [FLOAT_WIDTH-1:0] HALF_SNAN  = {1'b0, {EXPONENT_WIDTH{1'b1}}, 2'b01, {(FRACTION_WIDTH-2){1'b0}}};
   localparam logic [FLOAT_WIDTH-1:0] HALF_QNAN  = {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};

   localparam logic [EXPONENT_WIDTH-1:0] EXP_MIN  = EXPONENT_WIDTH'(1);
   localparam logic [EXPONENT_WIDTH-1:0] EXP_MAX  = {{(EXPONENT_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [EXPONENT_WIDTH-1:0] EXP_ZERO = {EXPONENT_WIDTH{1'b0}};

   typedef enum logic {
      IDLE,
      GEN
   } state_e;

   state_e                     state_q;
   logic [9:0]                 classLat_q;
   logic [COUNT_W-1:0]         remain_q;
   logic [15:0]                lfsr_q;
   logic [15:0]                lfsr_d;
   logic                       outValid_q;
   logic                       reqReady_q;
   logic                       err_q;
   logic                       busy_q;
   logic                       reqOk;
   logic [EXPONENT_WIDTH-1:0]  rndExp;
   logic [EXPONENT_WIDTH-1:0]  normExp;
   logic [FRACTION_WIDTH-1:0]  rndFrac;
   logic [FRACTION_WIDTH-1:0]  subFrac;
   logic [FLOAT_WIDTH-1:0]     floatVal;

   // The next LFSR step. It is committed only on a beat handshake.
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // A request is legal only when exactly one class bit is set and the burst is non-empty.
   assign reqOk = (req_class != 10'd0) && ((req_class & (req_class - 10'd1)) == 10'd0)
                  && (req_count != '0);

   // Raw random fields, plus clamped versions that keep values inside their class.
   // A normal exponent avoids 0 (subnormal/zero) and all-ones (inf/NaN).
   // A subnormal fraction avoids 0 (zero).
   assign rndExp  = lfsr_q[EXPONENT_WIDTH+FRACTION_WIDTH-1:FRACTION_WIDTH];
   assign rndFrac = lfsr_q[FRACTION_WIDTH-1:0];
   assign normExp = (rndExp == EXP_ZERO) ? EXP_MIN :
                    (&rndExp)            ? EXP_MAX : rndExp;
   assign subFrac = (rndFrac == '0) ? FRACTION_WIDTH'(1) : rndFrac;

   // The value depends only on the latched class and the LFSR.
   // It therefore holds steady while the downstream stalls.
   always_comb begin
      floatVal = HALF_ZERO;
      case (classLat_q)
         10'h001: floatVal = HALF_INFN;
         10'h002: floatVal = {1'b1, normExp, rndFrac};
         10'h004: floatVal = {1'b1, EXP_ZERO, subFrac};
         10'h008: floatVal = HALF_ZERON;
         10'h010: floatVal = HALF_ZERO;
         10'h020: floatVal = {1'b0, EXP_ZERO, subFrac};
         10'h040: floatVal = {1'b0, normExp, rndFrac};
         10'h080: floatVal = HALF_INF;
         10'h100: floatVal = HALF_SNAN;
         10'h200: floatVal = HALF_QNAN;
         default: floatVal = HALF_ZERO;
      endcase
   end

   // Request/burst FSM. All handshake flags are registered.
   // req_ready therefore stays low through reset and for the cycle of the final beat.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         classLat_q <= '0;
         remain_q   <= '0;
         lfsr_q     <= SEED_EFF;
         outValid_q <= 1'b0;
         reqReady_q <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               reqReady_q <= 1'b1;
               if (req_valid && reqReady_q) begin
                  if (!reqOk) begin
                     err_q <= 1'b1;
                  end else begin
                     classLat_q <= req_class;
                     remain_q   <= req_count;
                     state_q    <= GEN;
                     reqReady_q <= 1'b0;
                     outValid_q <= 1'b1;
                     busy_q     <= 1'b1;
                  end
               end
            end
            GEN: begin
               if (outValid_q && out_ready) begin
                  lfsr_q   <= lfsr_d;
                  remain_q <= remain_q - COUNT_W'(1);
                  if (remain_q == COUNT_W'(1)) begin
                     state_q    <= IDLE;
                     outValid_q <= 1'b0;
                     busy_q     <= 1'b0;
                     reqReady_q <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign req_ready = reqReady_q;
   assign out_valid = outValid_q;
   assign out_float = floatVal;
   assign out_last  = outValid_q && (remain_q == COUNT_W'(1));
   assign err       = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_float_class_gen.sv
module tb_float_class_gen;

   localparam int SEED = 16'hACE1;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_class;
   logic [7:0]  req_count;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_float;
   logic        out_last;
   logic        err;
   logic        busy;

   int checkCount = 0;
   int passCount  = 0;
   int mLfsr;

   float_class_gen dut (
      .CLK       (CLK),
      .RST       (RST),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_class (req_class),
      .req_count (req_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_float (out_float),
      .out_last  (out_last),
      .err       (err),
      .busy      (busy)
   );

   // Free-running clock.
   always #5 CLK = ~CLK;

   // Every comparison funnels through here.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // One step of the reference LFSR.
   // Shift left by one, and feed in the parity of taps 15, 13, 12 and 10.
   function automatic int lfsrStep(input int l);
      int fb;
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      return ((l * 2) % 65536) + fb;
   endfunction

   // Reference value for a class index, built with plain arithmetic on the half-float fields.
   function automatic int expectVal(input int cls, input int l);
      int e, f, ce, sf;
      e  = (l / 1024) % 32;
      f  = l % 1024;
      ce = (e == 0) ? 1 : ((e == 31) ? 30 : e);
      sf = (f == 0) ? 1 : f;
      case (cls)
         0: return 'hFC00;
         1: return 32768 + ce * 1024 + f;
         2: return 32768 + sf;
         3: return 32768;
         4: return 0;
         5: return sf;
         6: return ce * 1024 + f;
         7: return 'h7C00;
         8: return 'h7D00;
         default: return 'h7E00;
      endcase
   endfunction

   // Independent half-precision classifier used for the round-trip check.
   function automatic int classOf(input int v);
      int s, e, f, idx;
      s = (v >> 15) & 1;
      e = (v >> 10) & 31;
      f = v & 1023;
      if (e == 31)     idx = (f == 0) ? (s ? 0 : 7) : (((f & 512) != 0) ? 9 : 8);
      else if (e == 0) idx = (f == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
      else             idx = s ? 1 : 6;
      return 1 << idx;
   endfunction

   // Issue an illegal request and confirm the single-cycle err pulse.
   task automatic applyReject(input logic [9:0] cls, input int count);
      req_valid = 1'b1;
      req_class = cls;
      req_count = 8'(count);
      @(negedge CLK);
      req_valid = 1'b0;
      checkOutput("reject err pulse", err, 1);
      checkOutput("reject out_valid", out_valid, 0);
      checkOutput("reject busy", busy, 0);
      @(negedge CLK);
      checkOutput("reject err cleared", err, 0);
      checkOutput("reject still idle", req_ready, 1);
   endtask

   // Run one burst against the reference model.
   // stallMode selects how out_ready behaves: 0 always ready, 1 toggle, 2 random.
   // abortAt >= 0 asserts RST while that beat index is presented.
   task automatic applyStimulus(input logic [9:0] cls, input int count, input int stallMode,
                                input int abortAt);
      int clsIdx = 0;
      int beat = 0;
      int cyc = 0;
      logic toggle = 1'b1;
      logic hs;
      for (int i = 0; i < 10; i++) if (cls[i]) clsIdx = i;
      req_valid = 1'b1;
      req_class = cls;
      req_count = 8'(count);
      checkOutput("req_ready before accept", req_ready, 1);
      @(negedge CLK);
      req_valid = 1'b0;
      while (beat < count && cyc < count * 8 + 16) begin
         checkOutput("out_valid in burst", out_valid, 1);
         checkOutput("busy in burst", busy, 1);
         if (abortAt == beat) begin
            RST = 1'b1;
            out_ready = 1'b0;
            @(negedge CLK);
            checkOutput("abort out_valid", out_valid, 0);
            checkOutput("abort err", err, 0);
            checkOutput("abort req_ready", req_ready, 0);
            RST = 1'b0;
            mLfsr = SEED;
            @(negedge CLK);
            checkOutput("no beat after abort", out_valid, 0);
            checkOutput("ready after abort", req_ready, 1);
            return;
         end
         checkOutput("out_float", out_float, expectVal(clsIdx, mLfsr));
         checkOutput("out_last", out_last, (beat == count - 1) ? 1 : 0);
         checkOutput("round trip class", classOf(out_float), cls);
         case (stallMode)
            0: out_ready = 1'b1;
            1: begin out_ready = toggle; toggle = ~toggle; end
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         hs = out_ready;
         @(negedge CLK);
         cyc++;
         if (hs) begin
            beat++;
            mLfsr = lfsrStep(mLfsr);
         end
      end
      if (beat < count) checkOutput("burst timeout", beat, count);
      checkOutput("out_valid after burst", out_valid, 0);
      checkOutput("req_ready after burst", req_ready, 1);
      checkOutput("busy after burst", busy, 0);
   endtask

   // Test sequence: reset, directed bursts, rejects, abort, then random bursts.
   initial begin
      RST       = 1'b1;
      req_valid = 1'b0;
      req_class = '0;
      req_count = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out_last", out_last, 0);
      checkOutput("reset err", err, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset req_ready", req_ready, 0);
      RST = 1'b0;
      mLfsr = SEED;
      @(negedge CLK);
      checkOutput("idle req_ready", req_ready, 1);

      applyStimulus(10'h080, 3, 0, -1);
      applyReject(10'h003, 1);
      applyReject(10'h040, 0);
      applyReject(10'h000, 2);
      applyStimulus(10'h040, 8, 1, -1);
      applyStimulus(10'h004, 4, 2, -1);
      for (int i = 0; i < 10; i++) applyStimulus(10'(1 << i), 16, 2, -1);
      applyStimulus(10'h040, 10, 0, 2);
      applyStimulus(10'h040, 10, 0, -1);
      applyStimulus(10'h100, 1, 0, -1);
      repeat (10) applyStimulus(10'(1 << $urandom_range(0, 9)), $urandom_range(1, 6), 2, -1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
